// File: rtl/plc_timer_pkg.sv
// Shared mode codes and constants for the PLC timer bank.
package plc_timer_pkg;

  localparam logic [1:0] MODE_TON     = 2'b00;
  localparam logic [1:0] MODE_TOF     = 2'b01;
  localparam logic [1:0] MODE_TP      = 2'b10;
  localparam logic [1:0] MODE_DIS_RTO = 2'b11;

  localparam int DEFAULT_PRESET = 0;

  // Channel-select width, kept at least one bit for a single-channel bank
  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/plc_timer_bank_if.sv
// Configuration and elapsed-readback bus of the PLC timer bank.
interface plc_timer_bank_if
  import plc_timer_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 16
) ();

  localparam int CH_W = ch_width(NUM_CH);

  logic             cfg_we;
  logic [CH_W-1:0]  cfg_ch;
  logic [1:0]       cfg_mode;
  logic [CNT_W-1:0] cfg_preset;
  logic [CH_W-1:0]  rd_ch;
  logic [CNT_W-1:0] rd_elapsed;

  modport master (
    output cfg_we, cfg_ch, cfg_mode, cfg_preset, rd_ch,
    input  rd_elapsed
  );

  modport slave (
    input  cfg_we, cfg_ch, cfg_mode, cfg_preset, rd_ch,
    output rd_elapsed
  );

endinterface

// File: rtl/plc_timer_ch.sv
// One timer channel: mode/preset/count/q/edge registers (TON, TOF, TP, disabled).
// Mode 11 becomes a retentive on-delay (RTO) when PLC_TIMER_RETENTIVE_EN is defined.
module plc_timer_ch
  import plc_timer_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             tick,
  input  logic             in_en,
  input  logic             load,
  input  logic [1:0]       cfg_mode,
  input  logic [CNT_W-1:0] cfg_preset,
  output logic             q,
  output logic [CNT_W-1:0] count
);

  logic [1:0]       mode, mode_nxt;
  logic [CNT_W-1:0] preset, preset_nxt, count_nxt;
  logic             q_nxt, prev_in, prev_nxt;
  logic             at_preset, step;

  // Counts saturate: a tick only advances the count while it is below preset
  assign at_preset = (count >= preset);
  assign step      = tick && !at_preset;

  always_comb begin
    mode_nxt   = mode;
    preset_nxt = preset;
    count_nxt  = count;
    q_nxt      = q;
    prev_nxt   = prev_in;
    if (load) begin
      mode_nxt   = cfg_mode;
      preset_nxt = cfg_preset;
      count_nxt  = '0;
      q_nxt      = 1'b0;
      prev_nxt   = 1'b0;
    end else if (ena) begin
      prev_nxt = in_en;
      case (mode)
        MODE_TON: begin
          if (!in_en) begin
            count_nxt = '0;
            q_nxt     = 1'b0;
          end else begin
            q_nxt = at_preset;
            if (step) count_nxt = count + CNT_W'(1);
          end
        end
        MODE_TOF: begin
          if (in_en) begin
            count_nxt = '0;
            q_nxt     = 1'b1;
          end else if (q) begin
            q_nxt = !at_preset;
            if (step) count_nxt = count + CNT_W'(1);
          end
        end
        MODE_TP: begin
          if (!q) begin
            if (in_en && !prev_in) begin
              count_nxt = '0;
              q_nxt     = 1'b1;
            end
          end else begin
            q_nxt = !at_preset;
            if (step) count_nxt = count + CNT_W'(1);
          end
        end
        default: begin
`ifdef PLC_TIMER_RETENTIVE_EN
          if (in_en && step) count_nxt = count + CNT_W'(1);
          q_nxt = q || at_preset;
`else
          count_nxt = '0;
          q_nxt     = 1'b0;
`endif
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mode    <= MODE_TON;
      preset  <= CNT_W'(DEFAULT_PRESET);
      count   <= '0;
      q       <= 1'b0;
      prev_in <= 1'b0;
    end else begin
      mode    <= mode_nxt;
      preset  <= preset_nxt;
      count   <= count_nxt;
      q       <= q_nxt;
      prev_in <= prev_nxt;
    end
  end

endmodule

// File: rtl/plc_timer_bank.sv
// Bank of NUM_CH PLC timers sharing one tick prescaler, with cfg decode and readback mux.
// Define PLC_TIMER_RETENTIVE_EN to turn mode 11 into a retentive on-delay (RTO).
module plc_timer_bank
  import plc_timer_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int CNT_W    = 16,
  parameter int PRESCALE = 1000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic [NUM_CH-1:0] in_en,
  output logic [NUM_CH-1:0] q,
  plc_timer_bank_if.slave   bus
);

  localparam int CH_W = ch_width(NUM_CH);
  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

  logic [PS_W-1:0]  ps_cnt;
  logic             tick;
  logic [NUM_CH-1:0] load;
  logic [CNT_W-1:0] elapsed [NUM_CH];
  logic [CNT_W-1:0] rd_mux;

  // Free-running prescaler; it is never realigned to the rung inputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ps_cnt <= '0;
    end else if (ena) begin
      ps_cnt <= (ps_cnt == PS_LAST) ? '0 : ps_cnt + PS_W'(1);
    end
  end

  assign tick = ena && (ps_cnt == PS_LAST);

  // Out-of-range channel numbers match no slot, so such writes and reads fall through
  always_comb begin
    load = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      load[i] = bus.cfg_we && (bus.cfg_ch == CH_W'(i));
    end
  end

  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (bus.rd_ch == CH_W'(i)) rd_mux = elapsed[i];
    end
  end

  assign bus.rd_elapsed = rd_mux;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    plc_timer_ch #(
      .CNT_W (CNT_W)
    ) u_ch (
      .clk        (clk),
      .rst_n      (rst_n),
      .ena        (ena),
      .tick       (tick),
      .in_en      (in_en[i]),
      .load       (load[i]),
      .cfg_mode   (bus.cfg_mode),
      .cfg_preset (bus.cfg_preset),
      .q          (q[i]),
      .count      (elapsed[i])
    );
  end

endmodule

// File: tb/tb_plc_timer_bank.sv
// Bench for plc_timer_bank: two instances (4 ch / PRESCALE 1, 3 ch / PRESCALE 4) against a timer model.
module tb_plc_timer_bank;
  import plc_timer_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n, ena, cfg_we;
  logic [3:0] in_en;
  logic [1:0] cfg_ch, cfg_mode, rd_ch;
  logic [7:0] cfg_preset;
  logic [3:0] q_a;
  logic [2:0] q_b;

  int n_checks = 0;
  int n_bad    = 0;

  always #5 clk = ~clk;

  plc_timer_bank_if #(.NUM_CH(4), .CNT_W(8)) bus_a ();
  plc_timer_bank_if #(.NUM_CH(3), .CNT_W(8)) bus_b ();

  assign bus_a.cfg_we     = cfg_we;
  assign bus_a.cfg_ch     = cfg_ch;
  assign bus_a.cfg_mode   = cfg_mode;
  assign bus_a.cfg_preset = cfg_preset;
  assign bus_a.rd_ch      = rd_ch;
  assign bus_b.cfg_we     = cfg_we;
  assign bus_b.cfg_ch     = cfg_ch;
  assign bus_b.cfg_mode   = cfg_mode;
  assign bus_b.cfg_preset = cfg_preset;
  assign bus_b.rd_ch      = rd_ch;

  plc_timer_bank #(.NUM_CH(4), .CNT_W(8), .PRESCALE(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .ena(ena), .in_en(in_en), .q(q_a), .bus(bus_a)
  );

  plc_timer_bank #(.NUM_CH(3), .CNT_W(8), .PRESCALE(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .ena(ena), .in_en(in_en[2:0]), .q(q_b), .bus(bus_b)
  );

  // Reference timers: index 0 models dut_a, index 1 models dut_b
  int m_mode   [2][4];
  int m_preset [2][4];
  int m_count  [2][4];
  bit m_q      [2][4];
  bit m_prev   [2][4];
  int m_enabled_cycles [2];

  function automatic int nch_of(input int d);
    return (d == 0) ? 4 : 3;
  endfunction

  function automatic int ps_of(input int d);
    return (d == 0) ? 1 : 4;
  endfunction

  task automatic check_output(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, actual, expected, $time);
    end
  endtask

  // One clock edge of the whole bank, stated directly from the timer rules
  task automatic model_step();
    bit tick, inp, done;
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) begin
        m_enabled_cycles[d] = 0;
        for (int c = 0; c < 4; c++) begin
          m_mode[d][c] = 0; m_preset[d][c] = 0; m_count[d][c] = 0;
          m_q[d][c] = 1'b0; m_prev[d][c] = 1'b0;
        end
        continue;
      end
      tick = ena && ((m_enabled_cycles[d] % ps_of(d)) == ps_of(d) - 1);
      if (ena) m_enabled_cycles[d]++;
      for (int c = 0; c < nch_of(d); c++) begin
        inp  = in_en[c];
        done = (m_count[d][c] >= m_preset[d][c]);
        if (cfg_we && (int'(cfg_ch) == c)) begin
          m_mode[d][c] = int'(cfg_mode); m_preset[d][c] = int'(cfg_preset);
          m_count[d][c] = 0; m_q[d][c] = 1'b0; m_prev[d][c] = 1'b0;
        end else if (ena) begin
          case (m_mode[d][c])
            0: begin
              if (!inp) begin m_count[d][c] = 0; m_q[d][c] = 1'b0; end
              else begin
                m_q[d][c] = done;
                if (tick && !done) m_count[d][c]++;
              end
            end
            1: begin
              if (inp) begin m_count[d][c] = 0; m_q[d][c] = 1'b1; end
              else if (m_q[d][c]) begin
                if (done) m_q[d][c] = 1'b0;
                else if (tick) m_count[d][c]++;
              end
            end
            2: begin
              if (!m_q[d][c]) begin
                if (inp && !m_prev[d][c]) begin m_q[d][c] = 1'b1; m_count[d][c] = 0; end
              end else begin
                if (done) m_q[d][c] = 1'b0;
                else if (tick) m_count[d][c]++;
              end
            end
            default: begin
`ifdef PLC_TIMER_RETENTIVE_EN
              if (inp && tick && !done) m_count[d][c]++;
              if (done) m_q[d][c] = 1'b1;
`else
              m_count[d][c] = 0; m_q[d][c] = 1'b0;
`endif
            end
          endcase
          m_prev[d][c] = inp;
        end
      end
    end
  endtask

  task automatic compare_all();
    logic [31:0] exp_qa, exp_qb, exp_ra, exp_rb;
    exp_qa = '0;
    exp_qb = '0;
    for (int c = 0; c < 4; c++) exp_qa[c] = m_q[0][c];
    for (int c = 0; c < 3; c++) exp_qb[c] = m_q[1][c];
    exp_ra = 32'(m_count[0][rd_ch]);
    exp_rb = (rd_ch < 2'd3) ? 32'(m_count[1][rd_ch]) : 32'd0;
    check_output("q_a", 32'(q_a), exp_qa);
    check_output("q_b", 32'(q_b), exp_qb);
    check_output("rd_a", 32'(bus_a.rd_elapsed), exp_ra);
    check_output("rd_b", 32'(bus_b.rd_elapsed), exp_rb);
  endtask

  task automatic run_cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic cfg_write(input logic [1:0] ch, input logic [1:0] mode, input logic [7:0] preset);
    cfg_we = 1'b1; cfg_ch = ch; cfg_mode = mode; cfg_preset = preset;
    run_cycle();
    cfg_we = 1'b0;
  endtask

  task automatic apply_stimulus();
    int b;
    if ($urandom_range(0, 7) == 0) begin
      b = $urandom_range(0, 3);
      in_en[b] = ~in_en[b];
    end
    ena        = ($urandom_range(0, 15) != 0);
    rst_n      = ($urandom_range(0, 399) != 0);
    cfg_we     = ($urandom_range(0, 23) == 0);
    cfg_ch     = 2'($urandom_range(0, 3));
    cfg_mode   = 2'($urandom_range(0, 3));
    cfg_preset = 8'($urandom_range(0, 6));
    rd_ch      = 2'($urandom_range(0, 3));
  endtask

  initial begin
    bit seen;
    rst_n = 1'b0; ena = 1'b1; in_en = '0; cfg_we = 1'b0;
    cfg_ch = '0; cfg_mode = '0; cfg_preset = '0; rd_ch = '0;
    repeat (2) run_cycle();
    check_output("reset_q_a", 32'(q_a), 32'd0);
    check_output("reset_rd_a", 32'(bus_a.rd_elapsed), 32'd0);
    rst_n = 1'b1;

    // TON preset 5 on ch0
    cfg_write(2'd0, MODE_TON, 8'd5);
    in_en[0] = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      run_cycle();
      check_output("ton_q", 32'(q_a[0]), 32'(k == 6));
    end
    check_output("ton_elapsed", 32'(bus_a.rd_elapsed), 32'd5);
    in_en[0] = 1'b0;
    run_cycle();
    check_output("ton_drop_q", 32'(q_a[0]), 32'd0);
    check_output("ton_drop_cnt", 32'(bus_a.rd_elapsed), 32'd0);

    // TOF preset 3 on ch1, with a re-rise mid-count
    cfg_write(2'd1, MODE_TOF, 8'd3);
    rd_ch = 2'd1;
    in_en[1] = 1'b1;
    run_cycle();
    check_output("tof_rise_q", 32'(q_a[1]), 32'd1);
    in_en[1] = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      run_cycle();
      check_output("tof_fall_q", 32'(q_a[1]), 32'(k < 4));
    end
    in_en[1] = 1'b1;
    run_cycle();
    in_en[1] = 1'b0;
    repeat (2) run_cycle();
    in_en[1] = 1'b1;
    run_cycle();
    check_output("tof_rerise_q", 32'(q_a[1]), 32'd1);
    check_output("tof_rerise_cnt", 32'(bus_a.rd_elapsed), 32'd0);

    // TP preset 4 on ch2, a retrigger inside the window is ignored
    cfg_write(2'd2, MODE_TP, 8'd4);
    rd_ch = 2'd2;
    in_en[2] = 1'b1;
    run_cycle();
    check_output("tp_start_q", 32'(q_a[2]), 32'd1);
    for (int k = 2; k <= 7; k++) begin
      in_en[2] = (k == 3);
      run_cycle();
      check_output("tp_window_q", 32'(q_a[2]), 32'(k <= 5));
    end
    in_en[2] = 1'b1;
    run_cycle();
    check_output("tp_restart_q", 32'(q_a[2]), 32'd1);
    rst_n = 1'b0;
    run_cycle();
    check_output("tp_reset_q", 32'(q_a), 32'd0);
    rst_n = 1'b1;
    in_en = '0;
    run_cycle();

    // cfg write lands on the edge where the count would reach preset
    rd_ch = 2'd0;
    cfg_write(2'd0, MODE_TON, 8'd3);
    in_en[0] = 1'b1;
    repeat (2) run_cycle();
    cfg_write(2'd0, MODE_TON, 8'd7);
    check_output("cfgwin_q", 32'(q_a[0]), 32'd0);
    check_output("cfgwin_cnt", 32'(bus_a.rd_elapsed), 32'd0);
    for (int k = 1; k <= 8; k++) begin
      run_cycle();
      check_output("cfgwin_new_q", 32'(q_a[0]), 32'(k == 8));
    end
    in_en[0] = 1'b0;

    // PRESCALE 4 TON preset 2 with ena frozen for 10 cycles mid-count
    cfg_write(2'd0, MODE_TON, 8'd2);
    in_en[0] = 1'b1;
    repeat (3) run_cycle();
    ena = 1'b0;
    for (int k = 0; k < 10; k++) begin
      run_cycle();
      check_output("freeze_q", 32'(q_b[0]), 32'd0);
    end
    ena = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      run_cycle();
      if (q_b[0]) seen = 1'b1;
    end
    check_output("freeze_rise_seen", 32'(seen), 32'd1);
    in_en[0] = 1'b0;

    // Full-width preset on ch3: saturates at 255; ch3 is out of range on dut_b
    cfg_write(2'd3, MODE_TON, 8'd255);
    rd_ch = 2'd3;
    in_en[3] = 1'b1;
    repeat (258) run_cycle();
    check_output("sat_cnt", 32'(bus_a.rd_elapsed), 32'd255);
    check_output("sat_q", 32'(q_a[3]), 32'd1);
    check_output("oor_rd_b", 32'(bus_b.rd_elapsed), 32'd0);
    in_en = '0;

`ifdef PLC_TIMER_RETENTIVE_EN
    rd_ch = 2'd0;
    cfg_write(2'd0, MODE_DIS_RTO, 8'd6);
    in_en[0] = 1'b1; repeat (3) run_cycle();
    in_en[0] = 1'b0; repeat (5) run_cycle();
    in_en[0] = 1'b1; repeat (3) run_cycle();
    check_output("rto_cnt", 32'(bus_a.rd_elapsed), 32'd6);
    in_en[0] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      run_cycle();
      check_output("rto_hold_q", 32'(q_a[0]), 32'd1);
    end
    cfg_write(2'd0, MODE_DIS_RTO, 8'd6);
    check_output("rto_clear_q", 32'(q_a[0]), 32'd0);
`else
    cfg_write(2'd0, MODE_DIS_RTO, 8'd2);
    in_en[0] = 1'b1;
    repeat (4) run_cycle();
    check_output("dis_q", 32'(q_a[0]), 32'd0);
    in_en[0] = 1'b0;
`endif

    // Randomized traffic checked every cycle against the model
    for (int n = 0; n < 3000; n++) begin
      apply_stimulus();
      run_cycle();
    end

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
